inst_mem_loader: RTL and testbench

- Writer-side counterpart to the processor's instruction fetch port: fills the instruction memory before the core runs.
- Receives a byte stream over a ready/valid interface and assembles little-endian 32-bit instruction words.
- Writes each word through a write port into the instruction memory, at consecutive addresses from 0.
- Holds the processor (cpu_hold) from load start until the last word is written.

---
 rtl/inst_mem_loader.sv | 99 +++++++++
 tb/tb_inst_mem_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive instruction memory addresses from 0.
// Latency: the write strobe comes 1 cycle after the 4th byte of a word is accepted.
// Backpressure: in_ready is high only in LOAD, so the stream stalls while a word is written.
// Ports: clk/rst (sync, active high); start/word_count load request;
//   in_valid/in_ready/in_byte byte stream; mem_write_* instruction memory write
//   port; cpu_hold stalls the core during a load; done marks load completion.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]          state;
  logic [1:0]          idx;       // next byte lane to fill
  logic [23:0]         asm_q;     // lower three bytes of the word being assembled
  logic [ADDR_WIDTH:0] word_cnt;  // words written so far in this load
  logic [ADDR_WIDTH:0] n_words;   // saturated word count captured at start
  logic [ADDR_WIDTH:0] n_eff;
  logic [ADDR_WIDTH:0] cnt_next;
  logic                xfer;

  // Requests above the memory depth saturate, so the counter can never walk
  // past the last address or wrap back to 0.
  always_comb begin
    n_eff = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  end

  assign cnt_next = word_cnt + 1'b1;

  // Outputs are decoded from state only: no path from in_valid to in_ready.
  assign in_ready         = (state == S_LOAD);
  assign mem_write_enable = (state == S_WRITE);
  assign cpu_hold         = (state == S_LOAD) || (state == S_WRITE);
  assign done             = (state == S_DONE);
  assign xfer             = in_valid && (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= 2'd0;
      asm_q          <= 24'd0;
      word_cnt       <= '0;
      n_words        <= '0;
      mem_write_addr <= '0;
      mem_write_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_words  <= n_eff;
            word_cnt <= '0;
            idx      <= 2'd0;
            state    <= (n_eff == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (idx == 2'd3) begin
              // 4th byte goes straight into the write data register.
              mem_write_data <= {in_byte, asm_q};
              mem_write_addr <= word_cnt[ADDR_WIDTH-1:0];
              state          <= S_WRITE;
            end else begin
              asm_q[{idx, 3'b000} +: 8] <= in_byte;
            end
            idx <= idx + 2'd1;
          end
        end
        S_WRITE: begin
          word_cnt <= cnt_next;
          idx      <= 2'd0;
          state    <= (cnt_next == n_words) ? S_DONE : S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready;
  logic        mem_write_enable;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        done;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int exp_addr = 0;
  int seq_err = 0;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_WIDTH(5), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .done(done)
  );

  // Write observer: counts strobes and checks addresses run 0,1,2,... per load.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (int'(mem_write_addr) != exp_addr) seq_err++;
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [5:0] wc);
    wr_cnt = 0;
    exp_addr = 0;
    start = 1'b1;
    word_count = wc;
    step();
    start = 1'b0;
  endtask

  // Present one byte and hold it until the DUT takes it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_byte = b;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
  endtask

  task automatic chk_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(mem_write_enable), 32'd1);
    chk({tag, "_addr"}, 32'(mem_write_addr), 32'(a));
    chk({tag, "_data"}, mem_write_data, d);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(mem_write_enable), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(mem_write_addr), 0);
    chk("rst_data", mem_write_data, 0);

    // Two words back-to-back
    do_start(6'd2);
    chk("t1_hold", 32'(cpu_hold), 1);
    chk("t1_ready", 32'(in_ready), 1);
    chk("t1_done", 32'(done), 0);
    send_word(32'h0010_0013);
    chk_write("t1_w0", 5'd0, 32'h0010_0013);
    chk("t1_w0_hold", 32'(cpu_hold), 1);
    chk("t1_w0_ready", 32'(in_ready), 0);
    send_word(32'h0020_0093);
    chk_write("t1_w1", 5'd1, 32'h0020_0093);
    step();
    chk("t1_done_end", 32'(done), 1);
    chk("t1_hold_end", 32'(cpu_hold), 0);
    chk("t1_ready_end", 32'(in_ready), 0);
    chk("t1_wr_cnt", 32'(wr_cnt), 2);

    // One word with a 3-cycle gap between bytes 2 and 3
    do_start(6'd1);
    chk("t2_done_clr", 32'(done), 0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_gap_ready", 32'(in_ready), 1);
      chk("t2_gap_we", 32'(mem_write_enable), 0);
    end
    send_byte(8'hAD);
    send_byte(8'hDE);
    chk_write("t2_w0", 5'd0, 32'hDEAD_BEEF);
    step();
    chk("t2_done", 32'(done), 1);
    chk("t2_wr_cnt", 32'(wr_cnt), 1);

    // Saturation: 40 requested, 32 written
    do_start(6'd40);
    for (int w = 0; w < 32; w++) begin
      logic [7:0] b0;
      b0 = 8'(w * 4);
      send_word({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    chk_write("t3_last", 5'd31, 32'h7F7E_7D7C);
    step();
    chk("t3_done", 32'(done), 1);
    for (int i = 0; i < 5; i++) step();
    chk("t3_wr_cnt", 32'(wr_cnt), 32);
    chk("t3_seq_err", 32'(seq_err), 0);

    // Zero-length load
    do_start(6'd0);
    chk("t4_done", 32'(done), 1);
    chk("t4_hold", 32'(cpu_hold), 0);
    chk("t4_we", 32'(mem_write_enable), 0);
    step();
    chk("t4_wr_cnt", 32'(wr_cnt), 0);

    // Reset in the middle of a 3-word load
    do_start(6'd3);
    send_word(32'h1122_3344);
    chk_write("t5_w0", 5'd0, 32'h1122_3344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_hold", 32'(cpu_hold), 0);
    chk("t5_rst_ready", 32'(in_ready), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_we", 32'(mem_write_enable), 0);
    chk("t5_rst_addr", 32'(mem_write_addr), 0);
    chk("t5_rst_data", mem_write_data, 0);
    step(); step();
    chk("t5_wr_cnt", 32'(wr_cnt), 1);
    do_start(6'd1);
    send_word(32'hCAFE_F00D);
    chk_write("t5_new", 5'd0, 32'hCAFE_F00D);
    step();
    chk("t5_new_done", 32'(done), 1);

    // Start pulsed mid-load is ignored
    do_start(6'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    start = 1'b1;
    word_count = 6'd5;
    step();
    start = 1'b0;
    send_byte(8'h03);
    send_byte(8'h04);
    chk_write("t6_w0", 5'd0, 32'h0403_0201);
    send_word(32'h0807_0605);
    chk_write("t6_w1", 5'd1, 32'h0807_0605);
    step();
    chk("t6_done", 32'(done), 1);
    for (int i = 0; i < 4; i++) step();
    chk("t6_wr_cnt", 32'(wr_cnt), 2);
    chk("t6_still_done", 32'(done), 1);
    do_start(6'd1);
    chk("t6_restart_done", 32'(done), 0);
    chk("t6_restart_hold", 32'(cpu_hold), 1);
    send_word(32'h0000_0073);
    chk_write("t6_restart_w0", 5'd0, 32'h0000_0073);
    step();
    chk("t6_restart_end", 32'(done), 1);
    chk("final_seq_err", 32'(seq_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
